// File: rtl/regfile_reader.sv
// Sequential read-out engine: walks a wrapping range of register indices through
// one regfile read port and streams each word over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; read address parked at 0
// RUN   | walking the range; ctrl_readReg = ptr, words loaded into the output slot
module regfile_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  input  logic              abort,
  output logic [ADDR_W-1:0] ctrl_readReg,
  input  logic [DATA_W-1:0] data_readReg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] span;
  logic              accept;
  logic              load;
  logic              finish;

  // Span wraps naturally in ADDR_W bits; the count needs one extra bit for the full range.
  assign span = last_reg - first_reg;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    accept       = out_valid & out_ready;
    load         = 1'b0;
    finish       = 1'b0;
    busy         = 1'b0;
    ctrl_readReg = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy         = 1'b1;
        ctrl_readReg = ptr;
        load         = (remaining != '0) && (!out_valid || out_ready);
        finish       = accept && out_last;
        if (abort || finish) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      ptr       <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= finish && !abort;
      if (state == IDLE) begin
        if (start) begin
          ptr       <= first_reg;
          remaining <= {1'b0, span} + (ADDR_W+1)'(1);
        end
      end else if (abort) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        remaining <= '0;
      end else if (load) begin
        // Read data is combinational for ptr, so it is captured in the same cycle.
        out_data  <= data_readReg;
        out_index <= ptr;
        out_valid <= 1'b1;
        out_last  <= (remaining == (ADDR_W+1)'(1));
        ptr       <= ptr + ADDR_W'(1);
        remaining <= remaining - (ADDR_W+1)'(1);
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/regfile_reader.md
# regfile_reader

Sequential read-out engine for the 32×32 register file. On a start pulse it walks a contiguous, optionally wrapping, range of register indices through one regfile read port. It streams each word out over a valid/ready handshake to a consumer such as the game's score/HUD display logic or a debug dump. It is the read-side counterpart to the regfile's write port: it drives the read address and consumes the read data.

## Interface
- `DATA_W`, default 32: register width; must match the regfile.
- `ADDR_W`, default 5: register index width. The index space is 2^ADDR_W = 32.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `ctrl_reset`  in  1: **synchronous, active-high reset**.
- `start`  in  1: one-cycle request. Sampled only in IDLE.
- `first_reg`  in  ADDR_W: first index of the range. Latched when `start` is accepted.
- `last_reg`  in  ADDR_W: last index of the range. Latched when `start` is accepted.
- `abort`  in  1: cancels a walk in progress.
- `ctrl_readReg`  out  ADDR_W: address to the regfile read port (A or B).
- `data_readReg`  in  DATA_W: combinational regfile read data for `ctrl_readReg`.
- `out_valid`  out  1: `out_data`, `out_index` and `out_last` are valid.
- `out_ready`  in  1: consumer accepts the word on this cycle.
- `out_data`  out  DATA_W: captured register word.
- `out_index`  out  ADDR_W: index the word was read from.
- `out_last`  out  1: this word is the final word of the range.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse after the last word is accepted.

## Operation
- States:
  - IDLE: `busy`=0, `ctrl_readReg`=0.
  - RUN.
- IDLE→RUN when `start`=1:
  - latch `ptr`←`first_reg` and `remaining`←((`last_reg`−`first_reg`) mod 32)+1, range 1..32.
  - `first_reg`==`last_reg` reads exactly one register.
  - `last_reg`<`first_reg` wraps 31→0. Example: first=30, last=1 reads 30,31,0,1.
  - first=0, last=31 reads all 32 registers. `remaining` needs ADDR_W+1 bits.
- RUN: `ctrl_readReg`=`ptr`. Load condition: `remaining`≠0 and (`out_valid`=0 or `out_ready`=1). On load:
  - `out_data`←`data_readReg`, `out_index`←`ptr`, `out_valid`←1
  - `out_last`←(`remaining`==1)
  - `ptr`←`ptr`+1 mod 32; `remaining`←`remaining`−1.
- If `out_valid`=1 and `out_ready`=1 with no load, `out_valid`←0.
- Handshake rules:
  - While `out_valid`=1 and `out_ready`=0, `out_data`, `out_index` and `out_last` hold stable. `ctrl_readReg` holds at the next index.
  - `out_valid` never drops without acceptance, except on abort or reset.
- RUN→IDLE when the word with `out_last`=1 is accepted. `done`=1 in the following cycle, which is the first IDLE cycle.
- `start` while in RUN is ignored. `start` in the same cycle `done` is high is accepted.
- `abort`=1 in RUN takes effect at the next edge:
  - →IDLE, `out_valid`←0, `out_last`←0, no `done`.
  - `abort` in IDLE has no effect. `abort` and `start` together in IDLE: `start` wins.
- The read data is a live snapshot. A regfile write to an index not yet loaded is visible in the stream. An index already loaded is not re-read.
- Register 0 is read like any other register and returns whatever the regfile supplies, which is 0.

## Timing
- Reset values: state IDLE, `ctrl_readReg`=0, `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `busy`=0, `done`=0. Reset mid-walk discards the walk with no `done`.
- Latency with `start` high at edge E:
  - `busy`=1 and `ctrl_readReg`=first after E.
  - `out_valid`=1 with the word for `first` after E+1.
- Throughput: one word per cycle while `out_ready`=1. An N-word range with `out_ready` held high takes N+1 cycles from `start` to the last acceptance. `done` follows one cycle after that.
- Regfile read is combinational: `data_readReg` is sampled in the same cycle `ctrl_readReg` is presented, so no wait state is needed.
- `done` and `busy` are never high together.

## Test plan
- Reset, then first=3, last=5, `out_ready`=1: words 3,4,5 on consecutive cycles with indices 3,4,5. `out_last` high only on 5. `done` one cycle after 5 is accepted. `busy` is high for exactly 4 cycles.
- Wrap: first=30, last=1, regs preloaded to 0x100+i: stream 0x11E, 0x11F, 0x000 (reg 0), 0x101. Indices 30,31,0,1.
- Full range: first=0, last=31: exactly 32 words, `out_last` on index 31. Single register: first=last=7 gives one word with `out_last`=1.
- Backpressure: first=8, last=10, `out_ready` low for 3 cycles after the first `out_valid`: `out_data`/`out_index`=8 held stable, `ctrl_readReg`=9 held. The stream then resumes 9,10 with no word lost or duplicated.
- Abort on the second word of a 0..15 walk: next cycle `out_valid`=0 and `busy`=0, with no `done`. A new `start` with first=2, last=2 then works normally.
- `ctrl_reset` mid-walk: all outputs at reset values next cycle. A `start` while busy is ignored, with the range unchanged.
